// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the single-cycle MIPS datapath (FETCH/DECODE/EXEC/MEM/WB).
// Optional perf counters are built only when MC_CTRL_PERF_EN is defined.
//
// state  | meaning
// FETCH  | latch op/funct from IM
// DECODE | legality check; illegal instructions retire here
// EXEC   | ALU step; beq retires here
// MEM    | data-memory access, held until mem_ready
// WB     | register write-back; retires R-type/ori/lui/lw
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IM,
  input  logic        mem_ready,
  output logic        RegDst,
  output logic        AluSrc,
  output logic        MemtoReg,
  output logic        Ext_op,
  output logic [1:0]  AluCtr,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IBeq,
  output logic        pc_en,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  state_t     state, state_n;
  logic [5:0] op, funct;
  logic       illegal_q, set_illegal;

  logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_legal;
  logic steer_en;

  // Only opcode and funct fields matter to control; the rest is datapath business.
  logic unused_im;
  assign unused_im = ^IM[25:6];

  assign is_addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_legal = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      op        <= 6'd0;
      funct     <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == FETCH) begin
        op    <= IM[31:26];
        funct <= IM[5:0];
      end
      if (set_illegal)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    IBeq        = 1'b0;
    pc_en       = 1'b0;
    set_illegal = 1'b0;
    case (state)
      FETCH: state_n = DECODE;
      DECODE: begin
        if (is_legal) begin
          state_n = EXEC;
        end else begin
          pc_en       = 1'b1;
          set_illegal = 1'b1;
          state_n     = FETCH;
        end
      end
      EXEC: begin
        if (is_beq) begin
          IBeq    = 1'b1;
          pc_en   = 1'b1;
          state_n = FETCH;
        end else if (is_lw || is_sw) begin
          state_n = MEM;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        // sw keeps the write strobe up for the whole handshake; memory commits on mem_ready.
        MemWrite = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            pc_en   = 1'b1;
            state_n = FETCH;
          end else begin
            state_n = WB;
          end
        end
      end
      WB: begin
        RegWrite = 1'b1;
        pc_en    = 1'b1;
        state_n  = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  assign steer_en = (state == EXEC) || (state == MEM) || (state == WB);

  always_comb begin
    RegDst   = 1'b0;
    AluSrc   = 1'b0;
    MemtoReg = 1'b0;
    Ext_op   = 1'b0;
    AluCtr   = 2'b00;
    if (steer_en) begin
      RegDst   = is_addu | is_subu;
      AluSrc   = is_ori | is_lui | is_lw | is_sw;
      MemtoReg = is_lw;
      Ext_op   = is_lw | is_sw | is_beq;
      if (is_subu || is_beq)
        AluCtr = 2'b01;
      else if (is_ori)
        AluCtr = 2'b10;
      else if (is_lui)
        AluCtr = 2'b11;
      else
        AluCtr = 2'b00;
    end
  end

  assign illegal = illegal_q;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (pc_en)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instret   = instret_q;
`else
  assign cycle_cnt = 32'd0;
  assign instret   = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction schedule model with randomized
// instruction mix, memory latency and don't-care input noise.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] IM;
  logic        mem_ready;
  logic        RegDst, AluSrc, MemtoReg, Ext_op;
  logic [1:0]  AluCtr;
  logic        RegWrite, MemWrite, IBeq, pc_en, illegal;
  logic [31:0] cycle_cnt, instret;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .IM(IM), .mem_ready(mem_ready),
    .RegDst(RegDst), .AluSrc(AluSrc), .MemtoReg(MemtoReg), .Ext_op(Ext_op),
    .AluCtr(AluCtr), .RegWrite(RegWrite), .MemWrite(MemWrite), .IBeq(IBeq),
    .pc_en(pc_en), .illegal(illegal), .cycle_cnt(cycle_cnt), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3,
                 C_LW = 4, C_SW = 5, C_BEQ = 6, C_ILL = 7;

  int total = 0;
  int bad   = 0;

  // model state
  logic        m_ill;
  logic [31:0] m_cyc, m_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [31:0] w);
    case (w[31:26])
      6'b000000: begin
        if (w[5:0] == 6'b100001) return C_ADDU;
        if (w[5:0] == 6'b100011) return C_SUBU;
        return C_ILL;
      end
      6'b001101: return C_ORI;
      6'b001111: return C_LUI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int instr_len(input int cls, input int n);
    case (cls)
      C_ILL:   return 2;
      C_BEQ:   return 3;
      C_SW:    return 4 + n;
      C_LW:    return 5 + n;
      default: return 4;
    endcase
  endfunction

  // {RegDst, AluSrc, MemtoReg, Ext_op, AluCtr[1:0], RegWrite, MemWrite, IBeq, pc_en}
  function automatic logic [9:0] exp_vec(input int cls, input int k, input int len);
    logic [5:0] steer;
    logic       fin;
    fin   = (k == len - 1);
    steer = 6'b0;
    if (k >= 2 && cls != C_ILL) begin
      case (cls)
        C_ADDU: steer = 6'b1000_00;
        C_SUBU: steer = 6'b1000_01;
        C_ORI:  steer = 6'b0100_10;
        C_LUI:  steer = 6'b0100_11;
        C_LW:   steer = 6'b0111_00;
        C_SW:   steer = 6'b0101_00;
        C_BEQ:  steer = 6'b0001_01;
        default: steer = 6'b0;
      endcase
    end
    return {steer,
            fin && (cls <= C_LW),
            (cls == C_SW) && (k >= 3),
            fin && (cls == C_BEQ),
            fin};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {RegDst, AluSrc, MemtoReg, Ext_op, AluCtr, RegWrite, MemWrite, IBeq, pc_en};
  endfunction

  function automatic logic [31:0] exp_cyc();
`ifdef MC_CTRL_PERF_EN
    return m_cyc;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_ret();
`ifdef MC_CTRL_PERF_EN
    return m_ret;
`else
    return 32'd0;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_ill = 1'b0;
    m_cyc = 32'd0;
    m_ret = 32'd0;
    check("reset_outputs", {22'd0, dut_vec()}, 32'd0);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_instret", instret, 32'd0);
    reset = 1'b0;
  endtask

  // Runs one instruction starting at a negedge while the DUT sits in FETCH.
  // pc_at = 1-based cycle where the DUT raised pc_en (-1 if never).
  task automatic run_instr(input logic [31:0] ir, input int n, input int abort_k, output int pc_at);
    int cls, len;
    logic [9:0] ev;
    cls   = classify(ir);
    len   = instr_len(cls, n);
    pc_at = -1;
    for (int k = 0; k < len; k++) begin
      IM = (k == 0) ? ir : $urandom;
      if ((cls == C_LW || cls == C_SW) && k >= 3 && k <= 3 + n)
        mem_ready = (k == 3 + n);
      else
        mem_ready = 1'($urandom_range(0, 1));
      #1;
      ev = exp_vec(cls, k, len);
      check("ctrl_outputs", {22'd0, dut_vec()}, {22'd0, ev});
      check("illegal_flag", {31'd0, illegal}, {31'd0, m_ill});
      check("cycle_cnt", cycle_cnt, exp_cyc());
      check("instret", instret, exp_ret());
      if (pc_en && pc_at < 0) pc_at = k + 1;
      if (k == abort_k) begin
        #2 reset = 1'b1;
        #1;
        check("abort_outputs", {22'd0, dut_vec()}, 32'd0);
        check("abort_cycle_cnt", cycle_cnt, 32'd0);
        return;
      end
      @(posedge clk);
      m_cyc = m_cyc + 32'd1;
      if (ev[0]) m_ret = m_ret + 32'd1;
      if (cls == C_ILL && k == 1) m_ill = 1'b1;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0: return {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
      1: return {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
      2: return {6'b001101, rs, rt, imm};
      3: return {6'b001111, 5'd0, rt, imm};
      4: return {6'b100011, rs, rt, imm};
      5: return {6'b101011, rs, rt, imm};
      6: return {6'b000100, rs, rt, imm};
      7: return {6'b000000, rs, rt, rd, 5'd0, 6'($urandom)};
      8: return $urandom;
      default: return {6'b100011, rs, rt, imm};
    endcase
  endfunction

  initial begin
    int p;
    reset     = 1'b1;
    IM        = 32'd0;
    mem_ready = 1'b0;
    m_ill     = 1'b0;
    m_cyc     = 32'd0;
    m_ret     = 32'd0;
    @(negedge clk);
    do_reset();

    run_instr(32'h00221821, 0, -1, p); check("addu_pc_cycle", p, 4);
    run_instr(32'h8C220004, 3, -1, p); check("lw_n3_pc_cycle", p, 8);
    run_instr(32'hAC220004, 0, -1, p); check("sw_n0_pc_cycle", p, 4);
    run_instr(32'h10220003, 0, -1, p); check("beq_pc_cycle", p, 3);
    run_instr(32'h34220FF0, 0, -1, p); check("ori_pc_cycle", p, 4);
    run_instr(32'hFC000000, 0, -1, p); check("illegal_pc_cycle", p, 2);
    run_instr(32'h00221821, 0, -1, p); check("addu_after_ill", p, 4);
    check("illegal_sticky", {31'd0, illegal}, 32'd1);

    @(negedge clk);
    do_reset();
    run_instr(32'hAC220004, 3, 4, p);
    do_reset();

    for (int i = 0; i < 10; i++) run_instr(32'h00221821, 0, -1, p);
`ifdef MC_CTRL_PERF_EN
    check("perf_cycle_40", cycle_cnt, 32'd40);
    check("perf_instret_10", instret, 32'd10);
`else
    check("perf_cycle_off", cycle_cnt, 32'd0);
    check("perf_instret_off", instret, 32'd0);
`endif

    for (int i = 0; i < 300; i++) run_instr(rand_instr(), $urandom_range(0, 3), -1, p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
